vu_peak_meter: RTL and testbench

// Downstream stage of log10_filter: converts the 6-bit log level into an 8-segment VU bargraph

---
 rtl/vu_peak_meter_if.sv | 28 ++
 rtl/vu_peak_meter.sv | 162 ++++++++++++++++
 tb/tb_vu_peak_meter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vu_peak_meter_if.sv
// vu_peak_meter_if
// Bundles the level input and display outputs of vu_peak_meter.
//   level_valid : qualifies level (producer -> meter)
//   level       : unsigned log magnitude (producer -> meter)
//   bar         : active-high bargraph, thermometer OR peak dot (meter -> consumer)
//   peak_idx    : registered peak segment count, 0..N_SEG (meter -> consumer)
//   led_n       : active-low, bit-reversed board LED drive (meter -> consumer)
// master drives level/level_valid; slave is the meter itself.
interface vu_peak_meter_if #(
    parameter int LEVEL_W = 6,
    parameter int N_SEG   = 8
);
    logic               level_valid;
    logic [LEVEL_W-1:0] level;
    logic [N_SEG-1:0]   bar;
    logic [3:0]         peak_idx;
    logic [N_SEG-1:0]   led_n;

    modport master (
        output level_valid, level,
        input  bar, peak_idx, led_n
    );

    modport slave (
        input  level_valid, level,
        output bar, peak_idx, led_n
    );
endinterface

// File: rtl/vu_peak_meter.sv
// vu_peak_meter
// Turns a log level into an N_SEG bargraph with a peak-hold dot. The peak holds
// for HOLD_CYCLES, then falls one segment every DECAY_CYCLES until it meets the
// current level. Three register stages: quantise, peak FSM, output.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : vu_peak_meter_if slave (level_valid, level in; bar, peak_idx, led_n out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_TRACK | peak equals cur, no timer running
// ST_HOLD  | peak frozen, hold_ctr counting toward HOLD_CYCLES-1
// ST_DECAY | peak above cur, drops one segment per DECAY_CYCLES
module vu_peak_meter #(
    parameter int LEVEL_W = 6,
    parameter int N_SEG   = 8,
    parameter logic [LEVEL_W*(N_SEG-1)-1:0] THRESH =
        {6'd45, 6'd39, 6'd32, 6'd26, 6'd20, 6'd13, 6'd7},
    parameter int HOLD_CYCLES  = 12_000_000,
    parameter int DECAY_CYCLES = 600_000
) (
    input  logic           clk,
    input  logic           rst,
    vu_peak_meter_if.slave bus
);

    localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int DECAY_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    // stage 1
    logic [3:0]         q_raw;
    logic [3:0]         cur_q, cur_d;
    logic               vld_q, vld_d;

    // stage 2
    state_t             state_q, state_d;
    logic [3:0]         peak_q, peak_d;
    logic [3:0]         cur2_q, cur2_d;
    logic [HOLD_W-1:0]  hold_ctr_q, hold_ctr_d;
    logic [DECAY_W-1:0] decay_ctr_q, decay_ctr_d;
    logic [3:0]         peak_next;

    // stage 3
    logic [N_SEG-1:0]   bar_q, bar_d;
    logic [N_SEG-1:0]   led_n_q, led_n_d;
    logic [3:0]         peak_idx_q, peak_idx_d;

    // Segment count is one plus the number of thresholds strictly below level,
    // so a valid sample always lights at least one segment.
    always_comb begin
        q_raw = 4'd1;
        for (int k = 0; k < N_SEG - 1; k++) begin
            if (THRESH[k*LEVEL_W +: LEVEL_W] < bus.level) begin
                q_raw = q_raw + 4'd1;
            end
        end
        cur_d = bus.level_valid ? q_raw : cur_q;
        vld_d = bus.level_valid;
    end

    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        hold_ctr_d  = hold_ctr_q;
        decay_ctr_d = decay_ctr_q;
        cur2_d      = cur_q;
        peak_next   = peak_q;

        // A sample at or above the peak re-arms the hold and overrides any
        // timer event landing in the same cycle.
        if (vld_q && (cur_q >= peak_q)) begin
            peak_d     = cur_q;
            hold_ctr_d = '0;
            state_d    = ST_HOLD;
        end else begin
            unique case (state_q)
                ST_TRACK: begin
                    if (cur_q < peak_q) begin
                        state_d     = ST_DECAY;
                        decay_ctr_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_ctr_q == HOLD_LAST) begin
                        hold_ctr_d  = '0;
                        decay_ctr_d = '0;
                        state_d     = ST_DECAY;
                    end else begin
                        hold_ctr_d = hold_ctr_q + HOLD_W'(1);
                    end
                end
                ST_DECAY: begin
                    if (decay_ctr_q == DECAY_LAST) begin
                        decay_ctr_d = '0;
                        peak_next   = (peak_q > cur_q) ? (peak_q - 4'd1) : peak_q;
                        peak_d      = peak_next;
                        if (peak_next == cur_q) begin
                            state_d = ST_TRACK;
                        end
                    end else begin
                        decay_ctr_d = decay_ctr_q + DECAY_W'(1);
                    end
                end
                default: state_d = ST_TRACK;
            endcase
        end
    end

    // cur2 travels alongside peak so the thermometer and the dot in one bar
    // word come from the same sample.
    always_comb begin
        bar_d = '0;
        for (int i = 0; i < N_SEG; i++) begin
            bar_d[i] = (i < int'(cur2_q)) ||
                       ((peak_q != 4'd0) && (i == int'(peak_q) - 1));
        end
        for (int i = 0; i < N_SEG; i++) begin
            led_n_d[i] = ~bar_d[N_SEG-1-i];
        end
        peak_idx_d = peak_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q       <= '0;
            vld_q       <= 1'b0;
            state_q     <= ST_TRACK;
            peak_q      <= '0;
            cur2_q      <= '0;
            hold_ctr_q  <= '0;
            decay_ctr_q <= '0;
            bar_q       <= '0;
            led_n_q     <= '1;
            peak_idx_q  <= '0;
        end else begin
            cur_q       <= cur_d;
            vld_q       <= vld_d;
            state_q     <= state_d;
            peak_q      <= peak_d;
            cur2_q      <= cur2_d;
            hold_ctr_q  <= hold_ctr_d;
            decay_ctr_q <= decay_ctr_d;
            bar_q       <= bar_d;
            led_n_q     <= led_n_d;
            peak_idx_q  <= peak_idx_d;
        end
    end

    assign bus.bar      = bar_q;
    assign bus.led_n    = led_n_q;
    assign bus.peak_idx = peak_idx_q;

endmodule

// File: tb/tb_vu_peak_meter.sv
// tb_vu_peak_meter
// Scoreboard bench for vu_peak_meter with a short hold/decay (16/4 clocks).
// The reference model tracks cur/peak with absolute-time deadlines; every issued
// cycle pushes the display expected two edges after the sampling edge, and a
// separate monitor pops one entry per clock edge and compares.
module tb_vu_peak_meter;

    localparam int HOLD  = 16;
    localparam int DECAY = 4;

    logic clk;
    logic rst;

    vu_peak_meter_if #(.LEVEL_W(6), .N_SEG(8)) bus ();

    vu_peak_meter #(
        .LEVEL_W(6),
        .N_SEG(8),
        .HOLD_CYCLES(HOLD),
        .DECAY_CYCLES(DECAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bar;
        logic [7:0] led;
        logic [3:0] pk;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   mon_en  = 1'b0;

    // reference model state
    typedef enum int {M_TRACK, M_HOLD, M_DECAY} mmode_t;
    int     m_cur, m_peak, m_t, m_deadline;
    mmode_t m_mode;
    int     thr[7] = '{7, 13, 20, 26, 32, 39, 45};

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int quant(int lvl);
        int q = 1;
        foreach (thr[k]) if (lvl > thr[k]) q++;
        return q;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int   b;
        b = (1 << m_cur) - 1;
        if (m_peak > 0) b = b | (1 << (m_peak - 1));
        e.bar = 8'(b);
        for (int i = 0; i < 8; i++) e.led[i] = ~e.bar[7-i];
        e.pk = 4'(m_peak);
        return e;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_peak = 0; m_t = 0; m_deadline = 0; m_mode = M_TRACK;
    endtask

    task automatic model_step(bit v, int lvl);
        int  q;
        bit  taken = 1'b0;
        if (v) begin
            q = quant(lvl);
            if (q >= m_peak) begin
                m_peak = q; m_cur = q; m_mode = M_HOLD;
                m_deadline = m_t + HOLD;
                taken = 1'b1;
            end else begin
                m_cur = q;
            end
        end
        if (!taken) begin
            case (m_mode)
                M_TRACK: if (m_cur < m_peak) begin
                    m_mode = M_DECAY; m_deadline = m_t + DECAY;
                end
                M_HOLD: if (m_t == m_deadline) begin
                    m_mode = M_DECAY; m_deadline = m_t + DECAY;
                end
                M_DECAY: if (m_t == m_deadline) begin
                    if (m_peak > m_cur) m_peak = m_peak - 1;
                    if (m_peak == m_cur) m_mode = M_TRACK;
                    else m_deadline = m_t + DECAY;
                end
                default: ;
            endcase
        end
        m_t++;
    endtask

    task automatic issue(bit v, int lvl);
        bus.level_valid = v;
        bus.level       = 6'(lvl);
        model_step(v, lvl);
        sb.push_back(expect_now());
    endtask

    task automatic drive(bit v, int lvl);
        @(negedge clk);
        issue(v, lvl);
    endtask

    task automatic prefill();
        exp_t z;
        z.bar = 8'h00; z.led = 8'hFF; z.pk = 4'd0;
        sb.push_back(z);
        sb.push_back(z);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk({tag, "_bar"},  int'(bus.bar),      0);
        chk({tag, "_led"},  int'(bus.led_n),    8'hFF);
        chk({tag, "_peak"}, int'(bus.peak_idx), 0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        prefill();
        issue(1'b0, 0);
        mon_en = 1'b1;
    endtask

    // monitor: one display word per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && !rst) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("bar",      int'(bus.bar),      int'(e.bar));
                    chk("led_n",    int'(bus.led_n),    int'(e.led));
                    chk("peak_idx", int'(bus.peak_idx), int'(e.pk));
                end
            end
        end
    end

    initial begin
        int sweep[7] = '{7, 8, 13, 14, 45, 46, 63};
        int lim;

        rst = 1'b1;
        bus.level_valid = 1'b0;
        bus.level = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // reset values, then idle with no valid
        do_reset("rst_init");
        repeat (5) drive(1'b0, 0);

        // quantiser boundaries
        foreach (sweep[i]) drive(1'b1, sweep[i]);
        repeat (3) drive(1'b0, 0);

        // full-scale then quiet: hold, stepwise decay, back to tracking
        do_reset("rst_t3");
        drive(1'b1, 50);
        repeat (60) drive(1'b1, 5);

        // q=6 lands exactly on a decay tick with peak=6
        drive(1'b1, 35);
        lim = 0;
        while (!(m_mode == M_DECAY && m_deadline == m_t && m_peak == 6) && lim < 60) begin
            drive(1'b1, 5);
            lim++;
        end
        chk("t4_reach_tick", lim < 60 ? 1 : 0, 1);
        drive(1'b1, 35);
        repeat (40) drive(1'b1, 5);

        // lower sample during hold with peak=8
        drive(1'b1, 60);
        repeat (4) drive(1'b1, 60);
        repeat (5) drive(1'b1, 30);
        repeat (25) drive(1'b0, 0);

        // reset mid-decay with peak=4, cur=1
        drive(1'b1, 21);
        lim = 0;
        while (m_mode != M_DECAY && lim < 40) begin
            drive(1'b1, 5);
            lim++;
        end
        chk("t6_reach_decay", lim < 40 ? 1 : 0, 1);
        repeat (2) drive(1'b1, 5);
        do_reset("rst_mid_decay");
        drive(1'b1, 20);
        repeat (6) drive(1'b0, 0);

        // randomized traffic with occasional quiet stretches
        for (int n = 0; n < 600; n++) begin
            if ((n / 50) % 3 == 2) drive(1'b1, $urandom_range(0, 10));
            else drive(($urandom_range(0, 2) == 0), $urandom_range(0, 63));
        end
        repeat (4) drive(1'b0, 0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
